// File: rtl/serial_regfile_seq_pkg.sv
// Shared types and parameter helpers for the bit-serial register file.
package serial_regfile_seq_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_SCAN = 1'b1} port_state_e;

  function automatic int nbeats(input int reg_bits, input int nshift);
    return reg_bits / nshift;
  endfunction

  function automatic int cnt_w(input int reg_bits, input int nshift);
    return $clog2(reg_bits / nshift);
  endfunction

  function automatic bit params_ok(input int reg_bits, input int nshift, input int nports);
    return (nshift > 0) && (reg_bits % nshift == 0) && (reg_bits / nshift >= 2) &&
           (nports >= 1) && (nports <= 4);
  endfunction

endpackage

// File: rtl/serial_regfile_seq_port.sv
// One scan-port sequencer: accepts a start, then walks NBEATS beats over the latched register.
module serial_scan_port
  import serial_regfile_seq_pkg::*;
#(
  parameter int LOG2_NR = 3,
  parameter int NBEATS  = 8,
  parameter int CW      = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [LOG2_NR-1:0] index_i,
  input  logic               write_en_i,
  input  logic               lock_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               last_o,
  output logic [CW-1:0]      bit_index_o,
  output logic [LOG2_NR-1:0] index_o,
  output logic               write_en_o
);

  port_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LOG2_NR-1:0] idx_q, idx_d;
  logic               we_q, we_d;
  logic               busy, last, ready, accept;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
    end
  end

  // A start during the last beat re-enters SCAN directly, giving gapless back-to-back scans.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    busy    = (state_q == ST_SCAN);
    last    = busy && (cnt_q == CW'(NBEATS - 1));
    ready   = (!busy || last) && !lock_i;
    accept  = start_i && ready;
    if (accept) begin
      state_d = ST_SCAN;
      cnt_d   = '0;
      idx_d   = index_i;
      we_d    = write_en_i;
    end else if (last) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign ready_o     = ready;
  assign busy_o      = busy;
  assign last_o      = last;
  assign bit_index_o = cnt_q;
  assign index_o     = idx_q;
  assign write_en_o  = we_q;

endmodule

// File: rtl/serial_regfile_seq.sv
// Bit-serial register file: storage, lock network between ports, per-port shift datapath, peek mux.
module serial_regfile_seq
  import serial_regfile_seq_pkg::*;
#(
  parameter int                   LOG2_NR     = 3,
  parameter int                   REG_BITS    = 16,
  parameter int                   NSHIFT      = 2,
  parameter int                   NPORTS      = 2,
  parameter logic [REG_BITS-1:0]  RESET_VALUE = '0
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [NPORTS-1:0]                                  start,
  input  logic [NPORTS-1:0][LOG2_NR-1:0]                     index,
  input  logic [NPORTS-1:0]                                  write_en,
  input  logic [NPORTS-1:0][NSHIFT-1:0]                      scan_in,
  output logic [NPORTS-1:0]                                  ready,
  output logic [NPORTS-1:0]                                  busy,
  output logic [NPORTS-1:0]                                  last,
  output logic [NPORTS-1:0][cnt_w(REG_BITS, NSHIFT)-1:0]     bit_index,
  output logic [NPORTS-1:0][NSHIFT-1:0]                      scan_out,
  input  logic [LOG2_NR-1:0]                                 peek_index,
  output logic [REG_BITS-1:0]                                peek_data
);

  localparam int NR     = 2 ** LOG2_NR;
  localparam int NBEATS = nbeats(REG_BITS, NSHIFT);
  localparam int CW     = cnt_w(REG_BITS, NSHIFT);

  if (!params_ok(REG_BITS, NSHIFT, NPORTS)) begin : g_bad_params
    $error("serial_regfile_seq: illegal REG_BITS/NSHIFT/NPORTS combination");
  end

  logic [NR-1:0][REG_BITS-1:0]   regs_q, regs_d;
  logic [NPORTS-1:0]             lock, we_l;
  logic [NPORTS-1:0][LOG2_NR-1:0] idx_l;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    serial_scan_port #(.LOG2_NR(LOG2_NR), .NBEATS(NBEATS), .CW(CW)) u_port (
      .clk_i      (clk),
      .rst_i      (reset),
      .start_i    (start[p]),
      .index_i    (index[p]),
      .write_en_i (write_en[p]),
      .lock_i     (lock[p]),
      .ready_o    (ready[p]),
      .busy_o     (busy[p]),
      .last_o     (last[p]),
      .bit_index_o(bit_index[p]),
      .index_o    (idx_l[p]),
      .write_en_o (we_l[p])
    );
  end

  // Accepts are resolved in port order so a lower port's win is visible when locking higher ports.
  always_comb begin
    logic [NPORTS-1:0] acc;
    acc  = '0;
    lock = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = 0; q < NPORTS; q++) begin
        if (q != p && busy[q] && !last[q] && idx_l[q] == index[p]) lock[p] = 1'b1;
        if (q < p && acc[q] && index[q] == index[p]) lock[p] = 1'b1;
      end
      acc[p] = start[p] && (!busy[p] || last[p]) && !lock[p];
    end
  end

  // The lock guarantees at most one busy port per register, so the writes never overlap.
  always_comb begin
    regs_d   = regs_q;
    scan_out = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (busy[p]) begin
        scan_out[p]      = regs_q[idx_l[p]][NSHIFT-1:0];
        regs_d[idx_l[p]] = {(we_l[p] ? scan_in[p] : regs_q[idx_l[p]][NSHIFT-1:0]),
                            regs_q[idx_l[p]][REG_BITS-1:NSHIFT]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= {NR{RESET_VALUE}};
    else       regs_q <= regs_d;
  end

  assign peek_data = regs_q[peek_index];

endmodule

// File: tb/tb_serial_regfile_seq.sv
// Randomized and directed bench for serial_regfile_seq against a transaction-level model.
module tb_serial_regfile_seq;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      start, write_en, ready, busy, last;
  logic [1:0][2:0] index;
  logic [1:0][1:0] scan_in, scan_out, bit_index;
  logic [2:0]      peek_index;
  logic [7:0]      peek_data;

  serial_regfile_seq #(.LOG2_NR(3), .REG_BITS(8), .NSHIFT(2), .NPORTS(2), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .index(index), .write_en(write_en),
    .scan_in(scan_in), .ready(ready), .busy(busy), .last(last), .bit_index(bit_index),
    .scan_out(scan_out), .peek_index(peek_index), .peek_data(peek_data)
  );

  always #5 clk = ~clk;

  // Model: register contents plus, per port, beats remaining and the scan's snapshot/write data.
  logic [7:0] mem [8];
  int         left [2];
  int         mr [2];
  bit         mwe [2];
  logic [7:0] snap [2];
  logic [7:0] wdat [2];
  bit         exp_acc [2];
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) mem[r] = 8'h00;
    for (int p = 0; p < 2; p++) begin
      left[p] = 0; mr[p] = 0; mwe[p] = 0; snap[p] = '0; wdat[p] = '0; exp_acc[p] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_last"}, 32'(last), 0);
    check({tag, "_bitidx"}, 32'(bit_index), 0);
    check({tag, "_scanout"}, 32'(scan_out), 0);
    check({tag, "_ready"}, 32'(ready), 32'h3);
  endtask

  // Called at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic cycle();
    bit lk, rdy, scanned;
    int k;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      k = 4 - left[p];
      check("busy", 32'(busy[p]), 32'(left[p] > 0));
      check("last", 32'(last[p]), 32'(left[p] == 1));
      check("bit_index", 32'(bit_index[p]), (left[p] > 0) ? k : 0);
      check("scan_out", 32'(scan_out[p]), (left[p] > 0) ? 32'((snap[p] >> (2 * k)) & 8'h3) : 0);
    end
    for (int p = 0; p < 2; p++) begin
      lk = 0;
      for (int q = 0; q < 2; q++) begin
        if (q != p && left[q] > 1 && mr[q] == int'(index[p])) lk = 1;
        if (q < p && exp_acc[q] && index[q] == index[p]) lk = 1;
      end
      rdy = (left[p] <= 1) && !lk;
      exp_acc[p] = start[p] && rdy;
      check("ready", 32'(ready[p]), 32'(rdy));
    end
    scanned = 0;
    for (int p = 0; p < 2; p++) if (left[p] > 0 && mr[p] == int'(peek_index)) scanned = 1;
    if (!scanned) check("peek", 32'(peek_data), 32'(mem[peek_index]));
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (left[p] > 0) begin
        k = 4 - left[p];
        wdat[p][2*k +: 2] = scan_in[p];
        left[p]--;
        if (left[p] == 0 && mwe[p]) mem[mr[p]] = wdat[p];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (exp_acc[p]) begin
        left[p] = 4; mr[p] = int'(index[p]); mwe[p] = write_en[p];
        snap[p] = mem[index[p]]; wdat[p] = '0;
      end
      exp_acc[p] = 0;
    end
    #1;
  endtask

  task automatic peek_check(input string tag, input logic [2:0] r, input logic [7:0] exp);
    peek_index = r;
    #1;
    check(tag, 32'(peek_data), 32'(exp));
  endtask

  initial begin
    logic [7:0] v0, v1;
    int i;
    reset = 1'b1; start = '0; write_en = '0; index = '0; scan_in = '0; peek_index = '0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    for (int r = 0; r < 8; r++) peek_check("rst_peek", 3'(r), 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: port0 writes r3 with beats 00,01,11,10
    v0 = 8'hB4;
    start = 2'b01; index[0] = 3'd3; write_en[0] = 1'b1;
    cycle();
    start = '0;
    for (int b = 0; b < 4; b++) begin scan_in[0] = v0[2*b +: 2]; cycle(); end
    peek_check("t1_r3", 3'd3, 8'hB4);

    // 2: port1 recirculates r3
    start = 2'b10; index[1] = 3'd3; write_en[1] = 1'b0;
    cycle();
    start = '0;
    for (int b = 0; b < 4; b++) begin scan_in[1] = 2'(b); cycle(); end
    peek_check("t2_r3", 3'd3, 8'hB4);

    // 3: both ports start on r5; port1 holds start until it wins
    start = 2'b11; index[0] = 3'd5; index[1] = 3'd5; write_en = 2'b00;
    cycle();
    start = 2'b10;
    for (i = 1; i < 10; i++) begin
      cycle();
      if (left[1] == 4) break;
    end
    check("t3_accept_beat", i, 4);
    start = '0;
    for (int b = 0; b < 4; b++) cycle();

    // 4: concurrent writes r1 = 0x5A (port0) and r2 = 0xC3 (port1)
    v0 = 8'h5A; v1 = 8'hC3;
    start = 2'b11; index[0] = 3'd1; index[1] = 3'd2; write_en = 2'b11;
    cycle();
    start = '0;
    for (int b = 0; b < 4; b++) begin
      scan_in[0] = v0[2*b +: 2]; scan_in[1] = v1[2*b +: 2]; cycle();
    end
    peek_check("t4_r1", 3'd1, 8'h5A);
    peek_check("t4_r2", 3'd2, 8'hC3);

    // 5: back-to-back on port0: write r0 = 0xFF, read it on the last beat
    start = 2'b01; index[0] = 3'd0; write_en[0] = 1'b1; scan_in[0] = 2'b11;
    cycle();
    start = '0;
    for (int b = 0; b < 3; b++) cycle();
    start = 2'b01; write_en[0] = 1'b0;
    cycle();
    start = '0;
    for (int b = 0; b < 4; b++) cycle();
    peek_check("t5_r0", 3'd0, 8'hFF);

    // 6: reset during beat 2 of a write to r4
    v0 = 8'h96;
    start = 2'b01; index[0] = 3'd4; write_en[0] = 1'b1;
    cycle();
    start = '0;
    for (int b = 0; b < 2; b++) begin scan_in[0] = v0[2*b +: 2]; cycle(); end
    scan_in[0] = v0[5:4];
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("t6");
    model_reset();
    peek_check("t6_r4", 3'd4, 8'h00);
    peek_check("t6_r1", 3'd1, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 2'b01; index[0] = 3'd4; write_en[0] = 1'b0;
    cycle();
    start = '0;
    for (int b = 0; b < 4; b++) cycle();

    // Random traffic with frequent index collisions
    for (int c = 0; c < 600; c++) begin
      start      = 2'($urandom_range(0, 3));
      index[0]   = 3'($urandom_range(0, 3));
      index[1]   = 3'($urandom_range(0, 3));
      write_en   = 2'($urandom_range(0, 3));
      scan_in    = 4'($urandom);
      peek_index = 3'($urandom_range(0, 7));
      cycle();
    end
    start = '0;
    for (int c = 0; c < 5; c++) cycle();
    for (int r = 0; r < 8; r++) peek_check("final_peek", 3'(r), mem[r]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_regfile_seq.md
# serial_regfile_seq

Bit-serial general register file with NPORTS independent scan ports. Each port owns a small sequencer: one start handshake scans a whole register NSHIFT bits per cycle. A scan either writes new data or recirculates the old data, so reads are non-destructive. The block sits between the bit-serial ALU/address datapath and the register storage. It provides per-port busy/last/bit-index status, a collision lock between ports and a parallel debug peek.

## Interface
Parameters:
- LOG2_NR, 3, log2 of register count (NR = 2**LOG2_NR)
- REG_BITS, 16, register width; must be a multiple of NSHIFT
- NSHIFT, 2, bits transferred per beat; NBEATS = REG_BITS/NSHIFT, which must be ≥ 2
- NPORTS, 2, number of scan ports, 1..4
- RESET_VALUE, 0, value every register takes on reset

Ports (per-port signals are packed, port p in slice p). CW = $clog2(NBEATS).
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  NPORTS  request a scan on port p
- index  in  NPORTS*LOG2_NR  register to scan; sampled on accept
- write_en  in  NPORTS  1 = write scan_in, 0 = recirculate; sampled on accept
- scan_in  in  NPORTS*NSHIFT  write data for the current beat
- ready  out  NPORTS  port can accept start this cycle (combinational)
- busy  out  NPORTS  port is in SCAN; a beat happens this cycle
- last  out  NPORTS  current beat is beat NBEATS-1
- bit_index  out  NPORTS*CW  beat number, 0..NBEATS-1
- scan_out  out  NPORTS*NSHIFT  low NSHIFT bits of the scanned register; 0 when not busy
- peek_index  in  LOG2_NR  debug register select
- peek_data  out  REG_BITS  full contents of regs[peek_index] (combinational)

## Operation
- Each port has an FSM with states ST_IDLE and ST_SCAN, a latched index, a latched write_en and a beat counter.
- Accept on port p = start[p] && ready[p]. On accept: latch index and write_en, go to ST_SCAN, counter := 0.
- Beat, meaning each cycle in ST_SCAN, with r = the latched index:
  - scan_out = regs[r][NSHIFT-1:0]
  - regs[r] <= {d, regs[r][REG_BITS-1:NSHIFT]}, where d = write_en ? scan_in : scan_out
  - counter increments
- After NBEATS beats:
  - a write scan leaves the register holding the scan_in beats, with beat 0 in the LSBs;
  - a recirculate scan leaves the register unchanged.
- When last is high and there is no accept, the port returns to ST_IDLE. If there is an accept in that cycle, it restarts ST_SCAN with counter := 0.
- ready[p] = (ST_IDLE || last[p]) && !locked[p].
- locked[p] is true if either of these holds:
  - some other port q is in ST_SCAN with latched index == index[p] and last[q] is low;
  - some lower-numbered port q < p accepts this cycle with index[q] == index[p].
- Consequence: two ports never scan the same register in the same cycle. On simultaneous starts, the lowest port wins; the loser keeps start held and is accepted after the winner's last beat.
- peek_data is read-only and has no effect on scans.

## Timing
- Accept in cycle t: beats fall in cycles t+1 .. t+NBEATS, and last is high in cycle t+NBEATS.
- Back-to-back: an accept during the last beat gives its first beat in the next cycle, with no bubble.
- Register updates become visible on peek_data the cycle after each beat.
- A start that is not accepted has no side effects.
- Reset (asynchronous, any time, including mid-scan):
  - all FSMs go to ST_IDLE, counters 0, latched state 0;
  - all registers take RESET_VALUE;
  - outputs: busy = 0, last = 0, bit_index = 0, scan_out = 0, ready = all ones (when no lock applies);
  - the interrupted scan is abandoned.

## Structure
- The shared package holds:
  - the port state enum (ST_IDLE, ST_SCAN);
  - the beat-count function NBEATS/CW as a $clog2 helper;
  - the parameter legality checks (divisibility, NBEATS ≥ 2).
- Sub-module serial_scan_port: one per port. It contains the FSM, the beat counter, the latched index and write_en, and the ready/last/busy logic, and takes the lock as an input.
- The top level holds:
  - register storage;
  - per-register write mux, with at most one active port by construction;
  - the lock network;
  - the read muxes and the peek mux.

## Test plan
Settings for all scenarios: REG_BITS=8, NSHIFT=2, NPORTS=2, RESET_VALUE=0, so NBEATS=4.
1. Reset → peek_data = 0x00 for all r, ready = 2'b11, busy = 0. Port0 write of r3 with scan_in beats 00,01,11,10 → last in beat 4, then peek(r3) = 0xB4.
2. Port1 recirculate scan of r3 (value 0xB4) → scan_out beats 00,01,11,10; bit_index 0,1,2,3; afterwards peek(r3) = 0xB4 still.
3. Both ports start on r5 in the same cycle → only port0 accepted and ready[1] = 0. Port1, with start held, is accepted during port0's last beat and beats in the next 4 cycles with no gap.
4. Port0 write r1 = 0x5A while port1 writes r2 = 0xC3, concurrently → both complete in 4 cycles and peek gives 0x5A and 0xC3.
5. Back-to-back on port0: write r0 = 0xFF, then start accepted on the last beat to read r0 → busy stays high for 8 cycles and the second scan outputs 11,11,11,11.
6. Reset asserted during beat 2 of a write to r4 = 0x96 → all outputs go to reset values at once, peek(r4) = 0x00, and a new scan is accepted after reset release.
